// File: rtl/display_share_ctrl.sv
// rtl/display_share_ctrl.sv - round-robin time-sliced sharing of one 7-segment display
//
// Grants the display to one of four requesters at a time. Each owner holds it for DWELL cycles,
// longer while its lock bit is high. The owner's 16-bit value is driven onto num.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req[3:0]     req[i] high: requester i wants the display
//   lock[3:0]    lock[i] high while i owns: keep ownership past the dwell end
//   data[63:0]   requester values, requester i on data[16*i+15:16*i]
//   num[15:0]    value for the display driver (registered)
//   gnt[3:0]     one-hot grant, zero when idle (registered)
//   blank        high when nobody owns the display (registered)
//   switch_pulse one-cycle pulse when gnt takes a new non-zero value (registered)
module display_share_ctrl #(
  parameter int unsigned DWELL = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  lock,
  input  logic [63:0] data,
  output logic [15:0] num,
  output logic [3:0]  gnt,
  output logic        blank,
  output logic        switch_pulse
);

  localparam logic [23:0] CNT_MAX = 24'(DWELL - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t      state, nxt_state;
  logic [1:0]  owner, nxt_owner;
  logic [1:0]  last;
  logic [23:0] cnt, nxt_cnt;
  logic        take;
  logic [2:0]  pick;

  // Returns {found, index}. Scans from+1, from+2, from+3, then from itself.
  // Walking from the farthest candidate down lets the nearest hit overwrite the others.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // In SHOW, last always equals owner, so last serves as the scan origin in every case.
  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_cnt   = cnt;
    take      = 1'b0;
    pick      = '0;
    case (state)
      IDLE: begin
        pick = rr_pick(req, last);
        if (pick[2]) begin
          nxt_state = SHOW;
          nxt_owner = pick[1:0];
          nxt_cnt   = '0;
          take      = 1'b1;
        end
      end
      SHOW: begin
        if (!req[owner]) begin
          // A release takes priority over the dwell end. The owner is excluded from the pick.
          pick    = rr_pick(req & ~(4'b0001 << owner), last);
          nxt_cnt = '0;
          if (pick[2]) begin
            nxt_owner = pick[1:0];
            take      = 1'b1;
          end else begin
            nxt_state = IDLE;
          end
        end else if (cnt == CNT_MAX) begin
          nxt_cnt = '0;
          if (!lock[owner]) begin
            // req[owner] is high, so this pick always finds someone.
            pick      = rr_pick(req, last);
            nxt_owner = pick[1:0];
            take      = (pick[1:0] != owner);
          end
        end else begin
          nxt_cnt = cnt + 24'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      owner        <= 2'd0;
      last         <= 2'd3;
      cnt          <= '0;
      gnt          <= '0;
      num          <= '0;
      blank        <= 1'b1;
      switch_pulse <= 1'b0;
    end else begin
      state        <= nxt_state;
      owner        <= nxt_owner;
      cnt          <= nxt_cnt;
      switch_pulse <= take;
      blank        <= (nxt_state == IDLE);
      if (nxt_state == SHOW) begin
        last <= nxt_owner;
        gnt  <= 4'b0001 << nxt_owner;
        num  <= data[{nxt_owner, 4'b0000} +: 16];
      end else begin
        gnt  <= '0;
        num  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_display_share_ctrl.sv
// tb/tb_display_share_ctrl.sv - directed and randomized checks of display_share_ctrl against a reference model
module tb_display_share_ctrl;

  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'hF;
  logic [3:0]  lock = 4'h0;
  logic [63:0] data = '0;
  logic [15:0] num;
  logic [3:0]  gnt;
  logic        blank;
  logic        switch_pulse;

  always #5 clk = ~clk;

  display_share_ctrl #(.DWELL(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .data(data),
    .num(num), .gnt(gnt), .blank(blank), .switch_pulse(switch_pulse)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the owner is -1 when idle. The age counts cycles since the slot started.
  int          m_owner;
  int          m_last;
  int          m_age;
  logic        m_pulse;
  logic [15:0] m_num;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_age   = 0;
    m_pulse = 1'b0;
    m_num   = '0;
  endtask

  task automatic model_step();
    int p;
    m_pulse = 1'b0;
    if (m_owner < 0) begin
      p = rr_pick(req, m_last);
      if (p >= 0) begin
        m_owner = p; m_last = p; m_age = 0; m_pulse = 1'b1;
      end
    end else if (!req[m_owner]) begin
      p = rr_pick(req & ~(4'b0001 << m_owner), m_last);
      m_age = 0;
      if (p >= 0) begin
        m_owner = p; m_last = p; m_pulse = 1'b1;
      end else begin
        m_owner = -1;
      end
    end else if (m_age == DW - 1) begin
      m_age = 0;
      if (!lock[m_owner]) begin
        p = rr_pick(req, m_last);
        if (p != m_owner) m_pulse = 1'b1;
        m_owner = p; m_last = p;
      end
    end else begin
      m_age++;
    end
    m_num = (m_owner < 0) ? 16'h0000 : data[16*m_owner +: 16];
  endtask

  function automatic logic [3:0] m_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic check_model();
    chk("model.gnt",   32'(gnt),          32'(m_gnt()));
    chk("model.num",   32'(num),          32'(m_num));
    chk("model.blank", 32'(blank),        32'(m_owner < 0));
    chk("model.pulse", 32'(switch_pulse), 32'(m_pulse));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  // Reset is asserted between edges so the checks show it acts without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst.gnt",   32'(gnt),          32'h0);
    chk("rst.num",   32'(num),          32'h0);
    chk("rst.blank", 32'(blank),        32'h1);
    chk("rst.pulse", 32'(switch_pulse), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    logic [3:0] exp_rr [13];
    exp_rr = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h8, 4'h8, 4'h1};

    // Reset with every requester asking, then requester 0 wins first.
    model_reset();
    req = 4'hF;
    do_reset();
    step();
    chk("rst.first_gnt", 32'(gnt), 32'h1);

    // Single requester and live data tracking.
    req = 4'h0;
    do_reset();
    req = 4'b0100;
    data[47:32] = 16'h1234;
    step();
    chk("single.gnt",   32'(gnt),          32'h4);
    chk("single.num",   32'(num),          32'h1234);
    chk("single.pulse", 32'(switch_pulse), 32'h1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (switch_pulse) n++;
    end
    chk("single.no_pulses", 32'(n), 32'h0);
    data[47:32] = 16'h4321;
    step();
    chk("single.num_follow", 32'(num), 32'h4321);

    // Round-robin from idle.
    req = 4'h0;
    do_reset();
    req = 4'b1011;
    for (int i = 0; i < 13; i++) begin
      step();
      chk($sformatf("rr.gnt%0d", i), 32'(gnt), 32'(exp_rr[i]));
      chk($sformatf("rr.pulse%0d", i), 32'(switch_pulse), 32'(i % 4 == 0));
    end

    // Lock extends ownership while another requester waits.
    req = 4'h0;
    do_reset();
    req = 4'b0010;
    step();
    req  = 4'b0011;
    lock = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("lock.hold%0d", i), 32'(gnt), 32'h2);
    end
    lock = 4'b0000;
    n = 0;
    while (gnt != 4'h1 && n < 8) begin
      step();
      n++;
    end
    chk("lock.wait", 32'(n), 32'h4);

    // Early release gives the next requester a full slot. Dropping all requests then goes idle.
    req = 4'h0;
    do_reset();
    req = 4'b1001;
    step();
    step();
    req = 4'b1000;
    step();
    chk("early.gnt",   32'(gnt),          32'h8);
    chk("early.pulse", 32'(switch_pulse), 32'h1);
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("early.slot%0d", i), 32'(gnt), 32'h8);
    end
    step();
    chk("early.next", 32'(gnt), 32'h1);
    req = 4'h0;
    step();
    chk("idle.gnt",   32'(gnt),   32'h0);
    chk("idle.num",   32'(num),   32'h0);
    chk("idle.blank", 32'(blank), 32'h1);

    // Reset mid-slot restores the round-robin pointer.
    req = 4'b0100;
    step();
    step();
    do_reset();
    req = 4'b0110;
    step();
    chk("midrst.gnt", 32'(gnt), 32'h2);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
        if ($urandom_range(3) == 0) data[16*b +: 16] = 16'($urandom);
      end
      if ($urandom_range(3) == 0) lock = 4'($urandom);
      if ($urandom_range(499) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/display_share_ctrl.md
# display_share_ctrl

Time-sliced arbiter that shares the single 4-digit 7-segment display between four requesters. Each requester presents a 16-bit value and a request; the controller grants the display round-robin, holds each owner for a programmable dwell time, and drives the display's `num` input with the owner's value. It sits directly in front of the `display` driver, whose `num` port it feeds, and runs on the same clock.

## Interface

- `DWELL`, default 1000: clock cycles per grant slot; legal range 2 to 2^24-1.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  4  `req[i]` high: requester i wants the display.
- `lock`  in  4  `lock[i]` high while i owns: extend ownership past dwell end.
- `data`  in  64  requester values; requester i uses `data[16*i+15:16*i]`.
- `num`  out  16  value to display driver; registered.
- `gnt`  out  4  one-hot grant, or all-zero when idle; registered.
- `blank`  out  1  high when no owner; registered.
- `switch_pulse`  out  1  one-cycle pulse on the cycle `gnt` takes a new non-zero value; registered.

## Operation

- States: IDLE (no owner) and SHOW (owner valid). Internal regs: `owner[1:0]`, `last[1:0]` (round-robin pointer), 24-bit `cnt`.
- Round-robin pick: first i with `req[i]`=1 scanning `last+1, last+2, ...` mod 4, including `last` itself as final candidate.
- IDLE: `gnt`=0, `num`=0, `blank`=1. If any `req`: pick, go to SHOW, `owner`=`last`=pick, `cnt`=0.
- SHOW, each cycle, in priority order:
  - `req[owner]`=0: pick among remaining requests; none → IDLE; else new owner, `cnt`=0.
  - `cnt`=DWELL-1 and `lock[owner]`=1: stay, `cnt`=0.
  - `cnt`=DWELL-1: pick, with owner as final candidate. Same owner → stay, `cnt`=0, no pulse. Different owner → switch, `cnt`=0.
  - otherwise `cnt`=`cnt`+1.
- `num` is loaded every cycle with the data slice of the next-state owner, or 0 if the next state is IDLE. It tracks live data changes of the owner.
- `lock` of non-owners is ignored. `lock` never grants without `req`.
- `cnt` never exceeds DWELL-1. No wrap-around beyond that.

## Timing

- Reset (`rst`=0, async): `gnt`=0, `num`=0, `blank`=1, `switch_pulse`=0, state IDLE, `cnt`=0, `last`=3 (so requester 0 has first priority). These values take effect immediately, without a clock edge. Reset mid-slot discards the owner.
- Latency, request to grant: `req` high sampled at edge k in IDLE → `gnt`, `num`, `blank`=0 and `switch_pulse`=1 are all valid after edge k.
- `gnt`, `num`, `blank` and `switch_pulse` always change on the same edge. `num` lags the owner's `data` by exactly one cycle.
- Slot length without release or lock: exactly DWELL cycles of `gnt` high per owner.
- Release: owner drops `req` before edge k → the new grant, or IDLE, is visible after edge k, with no dead cycle.
- Simultaneous dwell end and owner release: release rule wins (owner excluded from pick).
- Simultaneous requests from IDLE: the pick order applies; no cycle with multiple `gnt` bits set.

## Test plan

- Reset: hold `rst`=0 with `req`=4'hF → `gnt`=0, `num`=16'h0000, `blank`=1, `switch_pulse`=0. Release reset; first edge gives `gnt`=4'b0001.
- Single requester, DWELL=4: `req`=4'b0100, data2=16'h1234 → next edge `gnt`=4'b0100, `num`=16'h1234, one `switch_pulse`. Run 20 cycles; no further pulses. Change data2 to 16'h4321 → `num` follows 1 cycle later.
- Round-robin, DWELL=4: `req`=4'b1011 from IDLE → `gnt` sequence 0001 (4 cycles), 0010 (4), 1000 (4), 0001. `switch_pulse` fires at each change.
- Lock, DWELL=4: owner 1 with `lock[1]`=1, `req[0]` waiting → `gnt`=0010 held for 12 cycles. Drop `lock[1]` → switch to 0001 at the next dwell end.
- Early release: owner 0 drops `req` at `cnt`=1 with `req[3]`=1 → next edge `gnt`=1000 with a full 4-cycle slot. Later, all `req` drop → next edge `gnt`=0, `num`=0, `blank`=1.
- Reset mid-slot: `rst` pulsed low during owner 2 → outputs go to reset values asynchronously. With `req`=4'b0110 after release → `gnt`=0010 first (`last`=3 restored).
